// File: rtl/cube_pkg.sv
// Shared cube-solver definitions: colour codes, the colour-code width, a
// validity helper and the state encoding of the colour sample stabilizer.
// The capture FSM imports the same colour constants.
package cube_pkg;

  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] CODE_W = 3'd0;
  localparam logic [COLOR_W-1:0] CODE_O = 3'd1;
  localparam logic [COLOR_W-1:0] CODE_G = 3'd2;
  localparam logic [COLOR_W-1:0] CODE_R = 3'd3;
  localparam logic [COLOR_W-1:0] CODE_B = 3'd4;
  localparam logic [COLOR_W-1:0] CODE_Y = 3'd5;

  // Codes 6 and 7 mean that the sensor saw no recognisable colour.
  function automatic logic is_valid_color(input logic [COLOR_W-1:0] code);
    return (code < 3'd6);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } stab_state_t;

endpackage

// File: rtl/color_sample_stabilizer_sample_matcher.sv
// sample_matcher: remembers the previous corner/edge reading pair and counts
// consecutive identical valid pairs, saturating at MATCH_COUNT.
// match_done is combinational: it flags the strobe whose updated count
// reaches MATCH_COUNT, and corner_match/edge_match carry that pair.
module sample_matcher
  import cube_pkg::*;
#(
  parameter int MATCH_COUNT = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic [COLOR_W-1:0] corner_in,
  input  logic [COLOR_W-1:0] edge_in,
  output logic               match_done,
  output logic [COLOR_W-1:0] corner_match,
  output logic [COLOR_W-1:0] edge_match
);

  localparam int CW = $clog2(MATCH_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MATCH_COUNT);

  logic [CW-1:0]      cnt, cnt_next;
  logic [COLOR_W-1:0] prev_c, prev_c_next;
  logic [COLOR_W-1:0] prev_e, prev_e_next;
  logic               pair_ok, pair_same;

  assign pair_ok   = is_valid_color(corner_in) && is_valid_color(edge_in);
  assign pair_same = (corner_in == prev_c) && (edge_in == prev_e);

  // Next count and stored pair; clear has priority over an incoming strobe.
  always_comb begin
    cnt_next    = cnt;
    prev_c_next = prev_c;
    prev_e_next = prev_e;
    if (clear) begin
      cnt_next = '0;
    end else if (sample_valid) begin
      if (!pair_ok) begin
        cnt_next = '0;
      end else if ((cnt != '0) && pair_same) begin
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end else begin
        cnt_next    = CW'(1);
        prev_c_next = corner_in;
        prev_e_next = edge_in;
      end
    end
  end

  assign match_done   = !clear && sample_valid && (cnt_next == CNT_MAX);
  assign corner_match = prev_c_next;
  assign edge_match   = prev_e_next;

  // Counter and previous-pair registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      prev_c <= '0;
      prev_e <= '0;
    end else begin
      cnt    <= cnt_next;
      prev_c <= prev_c_next;
      prev_e <= prev_e_next;
    end
  end

endmodule

// File: rtl/color_sample_stabilizer.sv
// color_sample_stabilizer: after a motors_done pulse, waits SETTLE_CYCLES,
// then waits for MATCH_COUNT consecutive identical valid corner/edge
// readings, latches them and pulses color_sensor_stable for one cycle.
// Optional macro COLOR_STABILIZER_TIMEOUT_EN adds a SAMPLE timeout that sets
// the sticky sample_timeout flag and retries from SETTLE.
// Handshake: motors_done and sample_valid are single-cycle strobes with no
// ready/backpressure; a strobe outside SAMPLE is dropped. color_sensor_stable
// is a one-cycle strobe qualifying corner_color/edge_color, which then hold
// until the next latch.
module color_sample_stabilizer
  import cube_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 65000,
  parameter int MATCH_COUNT    = 8,
  parameter int CNT_W          = 17,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 motors_done,
  input  logic                 sample_valid,
  input  logic [COLOR_W-1:0]   corner_raw,
  input  logic [COLOR_W-1:0]   edge_raw,
  output logic [COLOR_W-1:0]   corner_color,
  output logic [COLOR_W-1:0]   edge_color,
  output logic                 color_sensor_stable,
  output logic                 busy,
  output logic                 sample_timeout,
  output logic [1:0]           state_dbg
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  stab_state_t        state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               latch_en, stable_next;
  logic               match_clear, match_done;
  logic [COLOR_W-1:0] corner_match, edge_match;

  // Matcher only counts while sampling; any restart wipes its history.
  assign match_clear = (state != SAMPLE) || motors_done;

  sample_matcher #(.MATCH_COUNT(MATCH_COUNT)) u_matcher (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (match_clear),
    .sample_valid (sample_valid),
    .corner_in    (corner_raw),
    .edge_in      (edge_raw),
    .match_done   (match_done),
    .corner_match (corner_match),
    .edge_match   (edge_match)
  );

`ifdef COLOR_STABILIZER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_set;
  logic timeout_q;
`endif

  // Next-state logic; the shared counter counts down in SETTLE and up in
  // SAMPLE (timeout build only). motors_done always restarts the settle.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    latch_en    = 1'b0;
    stable_next = 1'b0;
`ifdef COLOR_STABILIZER_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (motors_done) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LAST;
        end
      end
      SETTLE: begin
        if (motors_done) begin
          cnt_next = SETTLE_LAST;
        end else if (cnt == '0) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (motors_done) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LAST;
        end else if (match_done) begin
          state_next  = IDLE;
          latch_en    = 1'b1;
          stable_next = 1'b1;
        end
`ifdef COLOR_STABILIZER_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_next  = SETTLE;
          cnt_next    = SETTLE_LAST;
          timeout_set = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter, output latches and the stable pulse register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      corner_color        <= '0;
      edge_color          <= '0;
      color_sensor_stable <= 1'b0;
    end else begin
      state               <= state_next;
      cnt                 <= cnt_next;
      color_sensor_stable <= stable_next;
      if (latch_en) begin
        corner_color <= corner_match;
        edge_color   <= edge_match;
      end
    end
  end

`ifdef COLOR_STABILIZER_TIMEOUT_EN
  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end
  end
  assign sample_timeout = timeout_q;
`else
  assign sample_timeout = 1'b0;
`endif

  assign busy      = (state == SETTLE) || (state == SAMPLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_color_sample_stabilizer.sv
// Testbench for color_sample_stabilizer: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a behavioural model that keeps
// the history of readings in a queue and a scoreboard of expected latches.
module tb_color_sample_stabilizer;
  import cube_pkg::*;

  localparam int SETTLE_CYCLES  = 4;
  localparam int MATCH_COUNT    = 3;
  localparam int TIMEOUT_CYCLES = 20;
`ifdef COLOR_STABILIZER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic       motors_done, sample_valid;
  logic [2:0] corner_raw, edge_raw;
  logic [2:0] corner_color, edge_color;
  logic       color_sensor_stable, busy, sample_timeout;
  logic [1:0] state_dbg;

  always #5 clock = ~clock;

  color_sample_stabilizer #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .MATCH_COUNT    (MATCH_COUNT),
    .CNT_W          (17),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .motors_done         (motors_done),
    .sample_valid        (sample_valid),
    .corner_raw          (corner_raw),
    .edge_raw            (edge_raw),
    .corner_color        (corner_color),
    .edge_color          (edge_color),
    .color_sensor_stable (color_sensor_stable),
    .busy                (busy),
    .sample_timeout      (sample_timeout),
    .state_dbg           (state_dbg)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_SETTLE = 1, M_SAMPLE = 2;
  int         m_mode, m_left, m_scyc;
  int         hist[$];            // readings since sampling began, -1 = invalid
  logic [2:0] e_corner, e_edge;
  logic       e_pulse, e_timeout;
  logic [5:0] exp_q[$];           // scoreboard of expected {corner, edge} latches

  function automatic void model_reset();
    m_mode = M_IDLE; m_left = 0; m_scyc = 0;
    hist.delete();
    e_corner = 3'd0; e_edge = 3'd0; e_pulse = 1'b0; e_timeout = 1'b0;
  endfunction

  // True when the last MATCH_COUNT readings are one and the same valid pair.
  function automatic bit run_complete();
    int last;
    if (hist.size() < MATCH_COUNT) return 0;
    last = hist[hist.size()-1];
    if (last < 0) return 0;
    for (int k = 1; k <= MATCH_COUNT; k++)
      if (hist[hist.size()-k] != last) return 0;
    return 1;
  endfunction

  function automatic void model_step(input logic md, input logic sv,
                                     input logic [2:0] c, input logic [2:0] e);
    e_pulse = 1'b0;
    case (m_mode)
      M_IDLE: if (md) begin m_mode = M_SETTLE; m_left = SETTLE_CYCLES; end
      M_SETTLE: begin
        if (md) m_left = SETTLE_CYCLES;
        else begin
          m_left--;
          if (m_left == 0) begin m_mode = M_SAMPLE; hist.delete(); m_scyc = 0; end
        end
      end
      default: begin
        if (md) begin
          m_mode = M_SETTLE; m_left = SETTLE_CYCLES;
        end else begin
          if (sv) hist.push_back((c < 6 && e < 6) ? int'(c) * 8 + int'(e) : -1);
          if (sv && run_complete()) begin
            e_corner = c; e_edge = e; e_pulse = 1'b1; m_mode = M_IDLE;
            exp_q.push_back({c, e});
          end else begin
            m_scyc++;
            if (TO_EN && m_scyc == TIMEOUT_CYCLES) begin
              e_timeout = 1'b1; m_mode = M_SETTLE; m_left = SETTLE_CYCLES;
            end
          end
        end
      end
    endcase
  endfunction

  task automatic compare_outputs();
    logic [5:0] want;
    check("stable", color_sensor_stable, e_pulse);
    check("corner_color", corner_color, e_corner);
    check("edge_color", edge_color, e_edge);
    check("busy", busy, (m_mode != M_IDLE));
    check("sample_timeout", sample_timeout, e_timeout);
    if (color_sensor_stable === 1'b1) begin
      check("sb_pending", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("sb_pair", {corner_color, edge_color}, want);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one cycle and checks just after the rise.
  task automatic step(input logic md, input logic sv, input logic [2:0] c, input logic [2:0] e);
    motors_done = md; sample_valid = sv; corner_raw = c; edge_raw = e;
    @(posedge clock);
    model_step(md, sv, c, e);
    #1;
    compare_outputs();
    @(negedge clock);
    motors_done = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic start_and_settle();
    step(1'b1, 1'b0, 3'd0, 3'd0);
    idle(SETTLE_CYCLES);
  endtask

  task automatic sample(input logic [2:0] c, input logic [2:0] e);
    step(1'b0, 1'b1, c, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] rc, re;
    reset_n = 1'b0; motors_done = 1'b0; sample_valid = 1'b0;
    corner_raw = 3'd0; edge_raw = 3'd0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_corner", corner_color, 3'd0);
    check("rst_edge", edge_color, 3'd0);
    check("rst_stable", color_sensor_stable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", sample_timeout, 1'b0);
    check("rst_state", state_dbg, 2'(IDLE));
    reset_n = 1'b1;

    // 1: three identical pairs after settle
    start_and_settle();
    sample(3'd2, 3'd4); sample(3'd2, 3'd4);
    check("s1_no_early", color_sensor_stable, 1'b0);
    sample(3'd2, 3'd4);
    check("s1_pulse", color_sensor_stable, 1'b1);
    check("s1_corner", corner_color, 3'd2);
    check("s1_edge", edge_color, 3'd4);
    idle(1);
    check("s1_one_cycle", color_sensor_stable, 1'b0);
    check("s1_busy_low", busy, 1'b0);

    // 2: change of pair restarts the run
    start_and_settle();
    sample(3'd2, 3'd4); sample(3'd2, 3'd4); sample(3'd2, 3'd5); sample(3'd2, 3'd5);
    check("s2_no_early", color_sensor_stable, 1'b0);
    sample(3'd2, 3'd5);
    check("s2_pulse", color_sensor_stable, 1'b1);
    check("s2_edge", edge_color, 3'd5);

    // 3: strobes in IDLE and SETTLE are ignored
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd3, 3'd3);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    for (int i = 0; i < SETTLE_CYCLES; i++) step(1'b0, 1'b1, 3'd3, 3'd3);
    sample(3'd3, 3'd3); sample(3'd3, 3'd3);
    check("s3_no_early", color_sensor_stable, 1'b0);
    sample(3'd3, 3'd3);
    check("s3_pulse", color_sensor_stable, 1'b1);

    // 4: invalid code breaks the run
    start_and_settle();
    sample(3'd1, 3'd3); sample(3'd7, 3'd3); sample(3'd1, 3'd3); sample(3'd1, 3'd3);
    check("s4_no_early", color_sensor_stable, 1'b0);
    sample(3'd1, 3'd3);
    check("s4_pulse", color_sensor_stable, 1'b1);
    check("s4_corner", corner_color, 3'd1);

    // 5: motors_done wins over the completing sample, then reset mid-SAMPLE
    start_and_settle();
    sample(3'd2, 3'd4); sample(3'd2, 3'd4);
    step(1'b1, 1'b1, 3'd2, 3'd4);
    check("s5_no_pulse", color_sensor_stable, 1'b0);
    check("s5_state", state_dbg, 2'(SETTLE));
    check("s5_hold_corner", corner_color, 3'd1);
    check("s5_hold_edge", edge_color, 3'd3);
    idle(SETTLE_CYCLES);
    sample(3'd0, 3'd5);
    reset_n = 1'b0;
    #1;
    check("s5_rst_corner", corner_color, 3'd0);
    check("s5_rst_edge", edge_color, 3'd0);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_stable", color_sensor_stable, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 3'd5);
    check("s5_quiet", busy, 1'b0);

    // 6: alternating pairs never settle
    start_and_settle();
    for (int i = 0; i < TIMEOUT_CYCLES + 2; i++)
      sample((i % 2) ? 3'd1 : 3'd0, (i % 2) ? 3'd1 : 3'd0);
    check("s6_timeout", sample_timeout, TO_EN);
    idle(SETTLE_CYCLES + 2);

    // random stimulus
    rc = 3'd0; re = 3'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) rc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 3) re = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), rc, re);
    end
    idle(2);
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
